rr_arb_64: RTL and testbench



---
 rtl/arb_pkg.sv | 35 +++
 rtl/pri_enc_64.sv | 37 +++
 rtl/rr_arb_64.sv | 107 ++++++++++
 tb/tb_rr_arb_64.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ============================================================================
// Module   : arb_pkg
// Brief    : Shared sizes, FSM encoding and an 8-bit lowest-set-bit helper
//            for the 64-way round-robin arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package arb_pkg;

    localparam int N_REQ   = 64;
    localparam int IDX_W   = 6;
    localparam int GRP_W   = 8;
    localparam int GRP_N   = 8;
    localparam int GRP_IDX = 3;

    localparam int ST_W = 1;
    localparam logic [ST_W-1:0] ST_IDLE  = 1'b0;
    localparam logic [ST_W-1:0] ST_GRANT = 1'b1;

    // Scanning downward means the lowest set bit is the last one written.
    function automatic logic [GRP_IDX-1:0] lsb8(input logic [GRP_W-1:0] v);
        logic [GRP_IDX-1:0] r;
        r = '0;
        for (int i = GRP_W - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = GRP_IDX'(i);
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pri_enc_64.sv
// ============================================================================
// Module   : pri_enc_64
// Brief    : Combinational 64-bit lowest-set-bit encoder, built as eight
//            8-bit group encoders plus one 8-bit group-select encoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pri_enc_64
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [GRP_N-1:0]   w_grp_any;
    logic [GRP_IDX-1:0] w_grp_idx [GRP_N];
    logic [GRP_IDX-1:0] w_sel;

    generate
        for (genvar g = 0; g < GRP_N; g++) begin : g_grp
            assign w_grp_any[g] = |vec[g*GRP_W +: GRP_W];
            assign w_grp_idx[g] = lsb8(vec[g*GRP_W +: GRP_W]);
        end
    endgenerate

    // Upper index bits pick the group, lower bits come from that group.
    always_comb begin
        w_sel = lsb8(w_grp_any);
        idx   = {w_sel, w_grp_idx[w_sel]};
        any   = |w_grp_any;
    end

endmodule

`default_nettype wire

// File: rtl/rr_arb_64.sv
// ============================================================================
// Module   : rr_arb_64
// Brief    : 64-requester round-robin arbiter with a registered, handshake-
//            locked 6-bit winner index for the downstream 6->64 decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb_64
    import arb_pkg::*;
#(
    parameter logic [5:0] PTR_INIT = 6'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    input  logic             gnt_ready,
    output logic [IDX_W-1:0] ptr
);

    logic [ST_W-1:0]  r_state;
    logic [ST_W-1:0]  w_state_nxt;
    logic [IDX_W-1:0] r_gnt_idx;
    logic [IDX_W-1:0] r_ptr;

    logic             w_fire;
    logic [IDX_W-1:0] w_idx_inc;
    logic [IDX_W-1:0] w_s;
    logic [N_REQ-1:0] w_rot;
    logic [IDX_W-1:0] w_enc_idx;
    logic             w_any;
    logic [IDX_W-1:0] w_winner;
    logic             w_load;

    assign w_fire    = gnt_valid & gnt_ready;
    assign w_idx_inc = r_gnt_idx + IDX_W'(1);
    assign w_s       = w_fire ? w_idx_inc : r_ptr;

    // Bit 0 of the rotated vector is requester s, so the encoder's lowest
    // set bit is the first requester at or above s, wrapping 63 -> 0.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            assign w_rot[gi] = req[w_s + IDX_W'(gi)];
        end
    endgenerate

    pri_enc_64 u_pri_enc (
        .vec (w_rot),
        .idx (w_enc_idx),
        .any (w_any)
    );

    assign w_winner = w_enc_idx + w_s;

    // A new grant is loaded from IDLE, or back-to-back when the current one fires.
    assign w_load = w_any & ((r_state == ST_IDLE) | w_fire);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_fire && !w_any) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt_valid = (r_state == ST_GRANT);
        gnt_idx   = r_gnt_idx;
        ptr       = r_ptr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt_idx <= '0;
            r_ptr     <= PTR_INIT;
        end else begin
            if (w_load) begin
                r_gnt_idx <= w_winner;
            end
            if (w_fire) begin
                r_ptr <= w_idx_inc;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rr_arb_64.sv
// ============================================================================
// Module   : tb_rr_arb_64
// Brief    : Directed self-checking bench for rr_arb_64 with a grant scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rr_arb_64;

    logic        clk;
    logic        rst;
    logic [63:0] req;
    logic        gnt_valid;
    logic [5:0]  gnt_idx;
    logic        gnt_ready;
    logic [5:0]  ptr;

    int errors;
    int checks;
    int exp_q[$];

    rr_arb_64 dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .gnt_ready (gnt_ready),
        .ptr       (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every accepted grant must match the next expected winner.
    always @(negedge clk) begin
        if (!rst && gnt_valid === 1'b1 && gnt_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_fire", 64'(gnt_idx), 64'd999);
            end else begin
                check("fire_idx", 64'(gnt_idx), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        req       = '1;
        gnt_ready = 1'b0;

        // Reset held with all requests pending
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_valid", 64'(gnt_valid), 64'd0);
            check("rst_idx",   64'(gnt_idx),   64'd0);
            check("rst_ptr",   64'(ptr),       64'd0);
        end
        rst = 1'b0;
        step();
        check("rel_valid", 64'(gnt_valid), 64'd1);
        check("rel_idx",   64'(gnt_idx),   64'd0);

        // Full rotation: 0..63,0,1 accepted, then 2 accepted as req drops
        for (int i = 0; i <= 66; i++) exp_q.push_back(i % 64);
        gnt_ready = 1'b1;
        for (int k = 1; k <= 66; k++) begin
            step();
            check("rot_valid", 64'(gnt_valid), 64'd1);
            check("rot_idx",   64'(gnt_idx),   64'(k % 64));
            check("rot_ptr",   64'(ptr),       64'(k % 64));
        end
        req = '0;
        step();
        check("rot_end_valid", 64'(gnt_valid), 64'd0);
        check("rot_end_ptr",   64'(ptr),       64'd3);

        // Backpressure lock with ptr=3
        gnt_ready = 1'b0;
        req = (64'd1 << 3) | (64'd1 << 10);
        exp_q.push_back(3);
        exp_q.push_back(10);
        for (int c = 1; c <= 4; c++) begin
            step();
            check("bp_valid", 64'(gnt_valid), 64'd1);
            check("bp_idx",   64'(gnt_idx),   64'd3);
            check("bp_ptr",   64'(ptr),       64'd3);
            if (c == 1) req = 64'd1 << 10;
        end
        gnt_ready = 1'b1;
        step();
        check("bp_next_idx", 64'(gnt_idx), 64'd10);
        check("bp_next_ptr", 64'(ptr),     64'd4);
        req = '0;
        step();
        check("bp_idle_valid", 64'(gnt_valid), 64'd0);
        check("bp_idle_ptr",   64'(ptr),       64'd11);

        // Single request from IDLE
        req = 64'd1 << 5;
        exp_q.push_back(5);
        step();
        check("single_valid", 64'(gnt_valid), 64'd1);
        check("single_idx",   64'(gnt_idx),   64'd5);
        check("single_ptr",   64'(ptr),       64'd11);
        req = '0;
        step();
        check("single_ptr_after", 64'(ptr),       64'd6);
        check("single_idle",      64'(gnt_valid), 64'd0);
        step();
        check("single_idle_hold", 64'(gnt_idx),   64'd5);

        // Wrap priority: accept 62, then bits 1 and 63 pending
        req = 64'd1 << 62;
        exp_q.push_back(62);
        step();
        check("wrap_62", 64'(gnt_idx), 64'd62);
        req = (64'd1 << 1) | (64'd1 << 63);
        exp_q.push_back(63);
        exp_q.push_back(1);
        step();
        check("wrap_63",     64'(gnt_idx), 64'd63);
        check("wrap_ptr_63", 64'(ptr),     64'd63);
        step();
        check("wrap_1",     64'(gnt_idx), 64'd1);
        check("wrap_ptr_0", 64'(ptr),     64'd0);
        req = '0;
        step();
        check("wrap_idle",  64'(gnt_valid), 64'd0);
        check("wrap_ptr_2", 64'(ptr),       64'd2);

        // Reset mid-grant: grant of 20 must never transfer
        gnt_ready = 1'b0;
        req = 64'd1 << 20;
        step();
        check("mid_valid", 64'(gnt_valid), 64'd1);
        check("mid_idx",   64'(gnt_idx),   64'd20);
        rst = 1'b1;
        gnt_ready = 1'b1;
        step();
        check("mid_rst_valid", 64'(gnt_valid), 64'd0);
        check("mid_rst_ptr",   64'(ptr),       64'd0);
        check("mid_rst_idx",   64'(gnt_idx),   64'd0);
        rst = 1'b0;
        gnt_ready = 1'b0;
        req = '0;
        step();
        check("post_rst_valid", 64'(gnt_valid), 64'd0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
